cc_branch_unit: RTL and testbench

- Parametrised condition-code and branch-enable unit for the LC-3 style datapath.
- Derives N/Z/P from a DATA_W-bit bus and evaluates the IR[11:9] branch mask into BEN.
- Adds a CC save/restore stack for interrupt entry/return, a CC-valid state, a sticky error flag and a saturating taken-branch counter.
- Sits between the bus, the control FSM (LD_CC, LD_BEN, CC_PUSH, CC_POP) and the BEN input of the FSM.

---
 rtl/cc_branch_unit.sv | 192 +++++++++++++++++++
 tb/tb_cc_branch_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cc_branch_unit.sv
// rtl/cc_branch_unit.sv - LC-3 condition-code / branch-enable unit with CC save stack
//
// Purpose: decodes N/Z/P from BUS, evaluates the IR[11:9] branch mask into
// BEN_out, keeps a small stack of saved condition codes for interrupt
// entry/return, tracks whether the condition code has ever been loaded,
// latches a sticky error flag and counts taken branch evaluations.
//
// Optional feature macro: CC_BEN_BYPASS_EN
//   When defined, an LD_BEN in the same cycle as LD_CC evaluates against the
//   freshly decoded BUS condition code and treats CC_valid as 1.
//
// Ports:
//   Clk          in   clock, rising edge
//   Reset        in   asynchronous reset, active-low
//   IR           in   instruction register, IR[11:9] = n/z/p branch mask
//   BUS          in   datapath bus, bit DATA_W-1 is the sign
//   LD_CC        in   load NZP from BUS decode
//   LD_BEN       in   evaluate branch into BEN_out
//   CC_PUSH      in   save current NZP onto the stack
//   CC_POP       in   restore NZP from the stack top
//   BEN_out      out  registered branch enable
//   NZP_out      out  current condition code {N,Z,P}
//   CC_valid     out  NZP loaded (or restored) since reset
//   stack_full   out  stack holds STACK_DEPTH entries
//   stack_empty  out  stack holds no entries
//   cc_err       out  sticky error flag
//   taken_count  out  saturating count of taken evaluations
module cc_branch_unit #(
    parameter int DATA_W      = 16,
    parameter int STACK_DEPTH = 4,
    parameter int CNT_W       = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [15:0]       IR,
    input  logic [DATA_W-1:0] BUS,
    input  logic              LD_CC,
    input  logic              LD_BEN,
    input  logic              CC_PUSH,
    input  logic              CC_POP,
    output logic              BEN_out,
    output logic [2:0]        NZP_out,
    output logic              CC_valid,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              cc_err,
    output logic [CNT_W-1:0]  taken_count
);

    localparam int PTR_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic {
        CC_INVALID = 1'b0,
        CC_VALID   = 1'b1
    } cc_state_e;

    cc_state_e          state_q, state_d;
    logic [2:0]         nzp_q, nzp_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               ben_q, ben_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               full_q, empty_q;
    logic [2:0]         stack_q [STACK_DEPTH];

    logic [2:0]         nzp_dec;
    logic [2:0]         ben_nzp;
    logic               ben_valid;
    logic               ben_eval;
    logic               push_ok, pop_ok, stack_err;
    logic [PTR_W-1:0]   ptr_m1;
    logic [IDX_W-1:0]   wr_idx, rd_idx;
    logic               unused_ir;

    assign unused_ir = ^{IR[15:12], IR[8:0]};

    // Zero takes priority over the sign bit, so the code is always one-hot.
    always_comb begin
        if (BUS == '0) begin
            nzp_dec = 3'b010;
        end else if (BUS[DATA_W-1]) begin
            nzp_dec = 3'b100;
        end else begin
            nzp_dec = 3'b001;
        end
    end

    // Simultaneous push and pop cancel each other and count as an error.
    assign push_ok   = CC_PUSH & ~CC_POP & ~full_q;
    assign pop_ok    = CC_POP & ~CC_PUSH & ~empty_q;
    assign stack_err = (CC_PUSH & CC_POP) | (CC_PUSH & ~CC_POP & full_q)
                     | (CC_POP & ~CC_PUSH & empty_q);

    assign ptr_m1 = ptr_q - PTR_W'(1);
    assign wr_idx = ptr_q[IDX_W-1:0];
    assign rd_idx = ptr_m1[IDX_W-1:0];

`ifdef CC_BEN_BYPASS_EN
    assign ben_nzp   = LD_CC ? nzp_dec : nzp_q;
    assign ben_valid = LD_CC | CC_valid;
`else
    assign ben_nzp   = nzp_q;
    assign ben_valid = CC_valid;
`endif

    assign ben_eval = ben_valid & (|(IR[11:9] & ben_nzp));

    // CC-valid FSM: state register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= CC_INVALID;
        end else begin
            state_q <= state_d;
        end
    end

    // CC-valid FSM: next state
    always_comb begin
        state_d = state_q;
        if (state_q == CC_INVALID && (LD_CC || pop_ok)) begin
            state_d = CC_VALID;
        end
    end

    // CC-valid FSM: output
    always_comb begin
        CC_valid = (state_q == CC_VALID);
    end

    // Datapath next state. LD_CC overrides popped data; the pointer still moves.
    always_comb begin
        nzp_d = nzp_q;
        ptr_d = ptr_q;
        ben_d = ben_q;
        err_d = err_q;
        cnt_d = cnt_q;
        if (push_ok) begin
            ptr_d = ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            ptr_d = ptr_m1;
            nzp_d = stack_q[rd_idx];
        end
        if (LD_CC) begin
            nzp_d = nzp_dec;
        end
        if (stack_err || (LD_BEN && !ben_valid)) begin
            err_d = 1'b1;
        end
        if (LD_BEN) begin
            ben_d = ben_eval;
            if (ben_eval && cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            nzp_q   <= 3'b010;
            ptr_q   <= '0;
            ben_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= 3'b010;
            end
        end else begin
            nzp_q   <= nzp_d;
            ptr_q   <= ptr_d;
            ben_q   <= ben_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            full_q  <= (ptr_d == PTR_W'(STACK_DEPTH));
            empty_q <= (ptr_d == '0);
            if (push_ok) begin
                stack_q[wr_idx] <= nzp_q;
            end
        end
    end

    assign BEN_out     = ben_q;
    assign NZP_out     = nzp_q;
    assign stack_full  = full_q;
    assign stack_empty = empty_q;
    assign cc_err      = err_q;
    assign taken_count = cnt_q;

endmodule

// File: tb/tb_cc_branch_unit.sv
// tb/tb_cc_branch_unit.sv - self-checking bench for cc_branch_unit
module tb_cc_branch_unit;

    localparam int DEPTH = 4;
    localparam int CW    = 2;
    localparam int CMAX  = (1 << CW) - 1;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [15:0] IR = '0;
    logic [15:0] BUS = '0;
    logic        LD_CC = 1'b0, LD_BEN = 1'b0, CC_PUSH = 1'b0, CC_POP = 1'b0;
    logic        BEN_out, CC_valid, stack_full, stack_empty, cc_err;
    logic [2:0]  NZP_out;
    logic [CW-1:0] taken_count;

    cc_branch_unit #(.DATA_W(16), .STACK_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .Clk(Clk), .Reset(Reset), .IR(IR), .BUS(BUS),
        .LD_CC(LD_CC), .LD_BEN(LD_BEN), .CC_PUSH(CC_PUSH), .CC_POP(CC_POP),
        .BEN_out(BEN_out), .NZP_out(NZP_out), .CC_valid(CC_valid),
        .stack_full(stack_full), .stack_empty(stack_empty),
        .cc_err(cc_err), .taken_count(taken_count)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    // Reference model state
    bit [2:0] m_nzp;
    bit       m_valid, m_ben, m_err;
    int       m_cnt;
    bit [2:0] m_stk[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    function automatic bit [2:0] decode(input logic [15:0] b);
        if (b == 16'd0) return 3'b010;
        if (b[15]) return 3'b100;
        return 3'b001;
    endfunction

    task automatic model_reset();
        m_nzp = 3'b010; m_valid = 0; m_ben = 0; m_err = 0; m_cnt = 0;
        m_stk.delete();
    endtask

    task automatic model_step();
        bit [2:0] old_nzp = m_nzp;
        bit [2:0] dec     = decode(BUS);
        bit [2:0] ev_nzp  = m_nzp;
        bit       ev_v    = m_valid;
        if (LD_BEN) begin
`ifdef CC_BEN_BYPASS_EN
            if (LD_CC) begin ev_nzp = dec; ev_v = 1; end
`endif
            m_ben = ev_v && ((IR[11:9] & ev_nzp) != 3'b000);
            if (!ev_v) m_err = 1;
            if (m_ben && m_cnt < CMAX) m_cnt++;
        end
        if (CC_PUSH && CC_POP) m_err = 1;
        else if (CC_PUSH) begin
            if (m_stk.size() == DEPTH) m_err = 1;
            else m_stk.push_back(old_nzp);
        end else if (CC_POP) begin
            if (m_stk.size() == 0) m_err = 1;
            else begin
                m_nzp   = m_stk.pop_back();
                m_valid = 1;
            end
        end
        if (LD_CC) begin m_nzp = dec; m_valid = 1; end
    endtask

    always @(negedge Clk) begin
        if (chk_en) begin
            check("nzp", NZP_out, m_nzp);
            check("ben", BEN_out, m_ben);
            check("valid", CC_valid, m_valid);
            check("err", cc_err, m_err);
            check("count", taken_count, m_cnt);
            check("full", stack_full, m_stk.size() == DEPTH);
            check("empty", stack_empty, m_stk.size() == 0);
        end
    end

    task automatic cyc(input logic ldcc, input logic ldben, input logic push, input logic pop,
                       input logic [15:0] bus, input logic [2:0] msk);
        @(negedge Clk);
        LD_CC = ldcc; LD_BEN = ldben; CC_PUSH = push; CC_POP = pop;
        BUS = bus; IR = 16'($urandom); IR[11:9] = msk;
        @(posedge Clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        chk_en = 0; Reset = 0;
        LD_CC = 0; LD_BEN = 0; CC_PUSH = 0; CC_POP = 0;
        model_reset();
        @(negedge Clk);
        Reset = 1; chk_en = 1;
    endtask

    initial begin
        model_reset();
        do_reset();
        check("rst_nzp", NZP_out, 3'b010);
        check("rst_empty", stack_empty, 1);
        check("rst_full", stack_full, 0);
        check("rst_valid", CC_valid, 0);

        // LD_BEN while invalid
        cyc(0, 1, 0, 0, 16'h0, 3'b111);
        check("inv_ben", BEN_out, 0);
        check("inv_err", cc_err, 1);
        check("inv_nzp", NZP_out, 3'b010);
        check("inv_cnt", taken_count, 0);

        // Negative load and branch
        do_reset();
        cyc(1, 0, 0, 0, 16'h8000, 3'b000);
        check("neg_nzp", NZP_out, 3'b100);
        cyc(0, 1, 0, 0, 16'h1234, 3'b100);
        check("neg_ben", BEN_out, 1);
        check("neg_cnt", taken_count, 1);
        cyc(0, 1, 0, 0, 16'h1234, 3'b011);
        check("nt_ben", BEN_out, 0);
        check("nt_cnt", taken_count, 1);

        // Stack fill, overflow, restore
        cyc(1, 0, 0, 0, 16'h0005, 3'b000);
        check("pos_nzp", NZP_out, 3'b001);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 16'h0, 3'b000);
        check("full4", stack_full, 1);
        check("noerr4", cc_err, 0);
        cyc(0, 0, 1, 0, 16'h0, 3'b000);
        check("ovf_err", cc_err, 1);
        check("ovf_full", stack_full, 1);
        cyc(1, 0, 0, 0, 16'h0000, 3'b000);
        check("zero_nzp", NZP_out, 3'b010);
        cyc(0, 0, 0, 1, 16'h0, 3'b000);
        check("pop_nzp", NZP_out, 3'b001);
        check("pop_full", stack_full, 0);

        // Same-cycle LD_CC + LD_BEN with prior NZP=001
        cyc(1, 1, 0, 0, 16'h0000, 3'b010);
`ifdef CC_BEN_BYPASS_EN
        check("byp_ben", BEN_out, 1);
`else
        check("byp_ben", BEN_out, 0);
`endif
        check("byp_nzp", NZP_out, 3'b010);

        // Saturation at CNT_W=2
        do_reset();
        cyc(1, 0, 0, 0, 16'h8000, 3'b000);
        begin
            int exp_seq[5] = '{1, 2, 3, 3, 3};
            for (int i = 0; i < 5; i++) begin
                cyc(0, 1, 0, 0, 16'h0, 3'b100);
                check("sat_cnt", taken_count, exp_seq[i]);
            end
        end

        // Asynchronous reset mid-push with pointer=2
        cyc(0, 0, 1, 0, 16'h0, 3'b000);
        cyc(0, 0, 1, 0, 16'h0, 3'b000);
        check("pre_empty", stack_empty, 0);
        @(negedge Clk);
        CC_PUSH = 1;
        #2;
        chk_en = 0; Reset = 0;
        #1;
        check("arst_empty", stack_empty, 1);
        check("arst_full", stack_full, 0);
        check("arst_nzp", NZP_out, 3'b010);
        check("arst_ben", BEN_out, 0);
        check("arst_cnt", taken_count, 0);
        check("arst_valid", CC_valid, 0);
        CC_PUSH = 0;
        model_reset();
        @(negedge Clk);
        Reset = 1; chk_en = 1;

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            logic [15:0] b;
            if ($urandom_range(0, 99) == 0) do_reset();
            case ($urandom_range(0, 3))
                0: b = 16'h0;
                1: b = 16'h8000 | 16'($urandom);
                default: b = 16'($urandom);
            endcase
            cyc($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 4,
                $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3,
                b, 3'($urandom));
        end

        @(negedge Clk);
        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
